// File: rtl/display_scanner_if.sv
// Load handshake and digit-drive signals for display_scanner.
// master = value producer / display hardware side, slave = the scanner itself.
interface display_scanner_if #(
    parameter int DIGITS = 4
);
    logic                  load_req;
    logic [4*DIGITS-1:0]   value;
    logic                  ready;
    logic                  load_ack;
    logic [3:0]            num;
    logic [DIGITS-1:0]     dig_sel;
    logic                  blank;
    logic                  frame_done;

    modport master (
        output load_req, value,
        input  ready, load_ack, num, dig_sel, blank, frame_done
    );

    modport slave (
        input  load_req, value,
        output ready, load_ack, num, dig_sel, blank, frame_done
    );
endinterface

// File: rtl/display_scanner.sv
// Multiplexed hex display scanner with a one-deep pending register swapped in only at frame
// boundaries. Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scanner #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst,
    display_scanner_if.slave   bus
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

    logic [PW-1:0]             presc;
    logic [IW-1:0]             idx;
    logic [DIGITS-1:0][3:0]    disp;
    logic [DIGITS-1:0][3:0]    pend;
    logic                      pend_full;

    logic tick, frame_tick, accept, transfer;

    assign tick       = (presc == PMAX);
    assign frame_tick = tick && (idx == IMAX);
    // A full pending register keeps ready low, so accept and transfer never coincide.
    assign accept     = bus.load_req && !pend_full;
    assign transfer   = frame_tick && pend_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            idx       <= '0;
            disp      <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick)
                idx <= (idx == IMAX) ? '0 : idx + 1'b1;
            if (transfer) begin
                disp      <= pend;
                pend_full <= 1'b0;
            end
            if (accept) begin
                pend      <= bus.value;
                pend_full <= 1'b1;
            end
        end
    end

    assign bus.ready      = !pend_full;
    assign bus.load_ack   = transfer;
    assign bus.frame_done = frame_tick;
    assign bus.num        = disp[idx];
    assign bus.dig_sel    = DIGITS'(1) << idx;

`ifdef LEADING_ZERO_BLANK_EN
    // upper_zero[k]: every nibble from k up to the most significant digit is zero
    logic [DIGITS-1:0] upper_zero;
    for (genvar k = 0; k < DIGITS; k++) begin : g_lz
        assign upper_zero[k] = (disp[DIGITS-1:k] == '0);
    end
    assign bus.blank = (idx != '0) && upper_zero[idx];
`else
    assign bus.blank = 1'b0;
`endif
endmodule
